// File: rtl/ttt_move_ctrl.sv
// ttt_move_ctrl: button debounce, move validation, mark commit, turn
// alternation and win/draw evaluation for the TicTacToe datapath.
// Optional build macro TTT_SCORE_EN adds saturating per-side win scores.
module ttt_move_ctrl #(
  parameter int DB_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn,
  input  logic [3:0]  sel,
  input  logic        ng,
  output logic        mv_stb,
  output logic [1:0]  cell_code,
  output logic        gend,
  output logic [17:0] board,
  output logic        turn,
  output logic [1:0]  winner,
  output logic        err
`ifdef TTT_SCORE_EN
  ,
  output logic [3:0]  score_x,
  output logic [3:0]  score_o
`endif
);

  typedef enum logic [1:0] {PLAY, COMMIT, EVAL, DONE} state_t;

  localparam logic [7:0] DB_LAST = 8'(DB_CYC - 1);

  logic        btn_p0, btn_p1;
  logic        db_lvl;
  logic [7:0]  db_cnt;
  logic        press_p2;

  state_t      state_q, state_d;
  logic [3:0]  sel_q;
  logic [3:0]  mcount;
  logic [1:0]  mover;
  logic        legal, win;
  logic        stb_d, err_d, latch_sel;

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] c;
    c = 2'b00;
    for (int i = 0; i < 9; i++)
      if (idx == 4'(i)) c = b[2*i +: 2];
    return c;
  endfunction

  function automatic logic has_line(input logic [17:0] b, input logic [1:0] code);
    logic [8:0] m;
    for (int i = 0; i < 9; i++)
      m[i] = (b[2*i +: 2] == code);
    return (&m[2:0]) | (&m[5:3]) | (&m[8:6]) |
           (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

`ifdef TTT_SCORE_EN
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction
`endif

  assign mover = turn ? 2'b10 : 2'b01;
  assign legal = (sel <= 4'd8) && (cell_at(board, sel) == 2'b00);
  assign win   = has_line(board, mover);

  // Synchronize the raw button, debounce it and emit a pulse on each accepted rising level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_p0   <= 1'b0;
      btn_p1   <= 1'b0;
      db_lvl   <= 1'b0;
      db_cnt   <= '0;
      press_p2 <= 1'b0;
    end else begin
      // stage p0/p1: two-flop synchronizer
      btn_p0   <= btn;
      btn_p1   <= btn_p0;
      // stage p2: debounce counter and press pulse
      press_p2 <= 1'b0;
      if (btn_p1 != db_lvl) begin
        if (db_cnt == DB_LAST) begin
          db_lvl   <= btn_p1;
          db_cnt   <= '0;
          press_p2 <= btn_p1;
        end else begin
          db_cnt <= db_cnt + 8'd1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Move FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= PLAY;
    else        state_q <= state_d;
  end

  // Next-state and strobe decode; a new-game request overrides everything.
  always_comb begin
    state_d   = state_q;
    stb_d     = 1'b0;
    err_d     = 1'b0;
    latch_sel = 1'b0;
    case (state_q)
      PLAY: begin
        if (press_p2) begin
          if (legal) begin
            state_d   = COMMIT;
            latch_sel = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COMMIT: begin
        stb_d   = 1'b1;
        state_d = EVAL;
      end
      EVAL: begin
        if (win || mcount == 4'd9) state_d = DONE;
        else                       state_d = PLAY;
      end
      default: state_d = DONE;
    endcase
    if (ng) begin
      state_d   = PLAY;
      stb_d     = 1'b0;
      err_d     = 1'b0;
      latch_sel = 1'b0;
    end
  end

  // Capture the target cell of an accepted move.
  always_ff @(posedge clk) begin
    if (latch_sel) sel_q <= sel;
  end

  // Board, turn, result and strobe registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      board     <= '0;
      turn      <= 1'b0;
      cell_code <= 2'b00;
      winner    <= 2'b00;
      gend      <= 1'b1;
      mcount    <= '0;
      mv_stb    <= 1'b0;
      err       <= 1'b0;
    end else begin
      mv_stb <= stb_d;
      err    <= err_d;
      if (ng) begin
        board     <= '0;
        turn      <= 1'b0;
        cell_code <= 2'b00;
        winner    <= 2'b00;
        gend      <= 1'b1;
        mcount    <= '0;
      end else begin
        case (state_q)
          COMMIT: begin
            for (int i = 0; i < 9; i++)
              if (sel_q == 4'(i)) board[2*i +: 2] <= mover;
            cell_code <= mover;
            mcount    <= mcount + 4'd1;
          end
          EVAL: begin
            if (win) begin
              winner <= mover;
              gend   <= 1'b0;
            end else if (mcount == 4'd9) begin
              winner <= 2'b11;
              gend   <= 1'b0;
            end else begin
              turn <= ~turn;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TTT_SCORE_EN
  // Per-side win tally; survives new-game requests, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      score_x <= '0;
      score_o <= '0;
    end else if (!ng && state_q == EVAL && win) begin
      if (turn) score_o <= sat_inc4(score_o);
      else      score_x <= sat_inc4(score_x);
    end
  end
`endif

endmodule
